// File: rtl/pipe_reg_elastic.sv
// -----------------------------------------------------------------------------
// pipe_reg_elastic
//
// Chain of STAGES elastic pipeline stages with a valid/ready handshake. Each
// stage holds a main entry and a skid entry. A stage's ready is taken straight
// from its own skid-valid flop, so there is no combinational path from
// out_ready_i back to in_ready_o and the chain still runs at one beat per
// cycle. A synchronous flush empties every stage and zeroes the payloads.
//
// Parameters:
//   DATA_W  payload width in bits (1..256)
//   STAGES  number of cascaded stages (1..4), nominal latency in cycles
//   CNT_W   width of count_o, 2**CNT_W must exceed 2*STAGES
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous reset, active LOW despite the name
//   flush_i      synchronous flush, discards all held beats
//   in_valid_i   upstream beat valid
//   in_ready_o   block accepts a beat this cycle (0 while in reset)
//   in_data_i    upstream payload
//   out_valid_o  output beat valid
//   out_ready_i  downstream accepts the output beat
//   out_data_o   output payload
//   count_o      number of valid entries held (0..2*STAGES)
// -----------------------------------------------------------------------------
module pipe_reg_elastic #(
   parameter int DATA_W = 32,
   parameter int STAGES = 1,
   parameter int CNT_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  count_o
);

   // The state encoding doubles as the occupancy flags: bit 1 is the main
   // valid (mv), bit 0 is the skid valid (sv). 2'b01 never occurs.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      TWO   = 2'b11
   } stage_state_e;

   stage_state_e      state_reg  [STAGES];
   stage_state_e      state_next [STAGES];
   logic [DATA_W-1:0] md_reg     [STAGES];
   logic [DATA_W-1:0] md_next    [STAGES];
   logic [DATA_W-1:0] sd_reg     [STAGES];
   logic [DATA_W-1:0] sd_next    [STAGES];

   // Per-stage view of its neighbours.
   logic              up_valid   [STAGES];
   logic [DATA_W-1:0] up_data    [STAGES];
   logic              dn_ready   [STAGES];

   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  count_next;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic acc;
         logic drn;

         if (gi == 0) begin : g_head
            assign up_valid[gi] = in_valid_i;
            assign up_data[gi]  = in_data_i;
         end else begin : g_link
            assign up_valid[gi] = state_reg[gi-1][1];
            assign up_data[gi]  = md_reg[gi-1];
         end

         // Downstream ready is the next stage's registered ~sv, which is what
         // keeps the ready path flop-to-flop across the whole chain.
         if (gi == STAGES - 1) begin : g_tail
            assign dn_ready[gi] = out_ready_i;
         end else begin : g_mid
            assign dn_ready[gi] = ~state_reg[gi+1][0];
         end

         assign acc = up_valid[gi] & ~state_reg[gi][0];
         assign drn = state_reg[gi][1] & dn_ready[gi];

         always_comb begin
            state_next[gi] = state_reg[gi];
            md_next[gi]    = md_reg[gi];
            sd_next[gi]    = sd_reg[gi];
            case (state_reg[gi])
               EMPTY: begin
                  if (acc) begin
                     state_next[gi] = ONE;
                     md_next[gi]    = up_data[gi];
                  end
               end
               ONE: begin
                  if (acc && !drn) begin
                     // Downstream stalled: park the new beat in the skid.
                     state_next[gi] = TWO;
                     sd_next[gi]    = up_data[gi];
                  end else if (!acc && drn) begin
                     state_next[gi] = EMPTY;
                  end else if (acc && drn) begin
                     // Pass-through: occupancy unchanged, payload replaced.
                     md_next[gi]    = up_data[gi];
                  end
               end
               TWO: begin
                  if (drn) begin
                     state_next[gi] = ONE;
                     md_next[gi]    = sd_reg[gi];
                  end
               end
               default: begin
                  state_next[gi] = EMPTY;
               end
            endcase
         end
      end
   endgenerate

   // Occupancy after the coming edge, so count_o lines up with the state.
   always_comb begin
      count_next = '0;
      for (int k = 0; k < STAGES; k++) begin
         count_next = count_next + CNT_W'(state_next[k][1])
                                 + CNT_W'(state_next[k][0]);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < STAGES; k++) begin
            state_reg[k] <= EMPTY;
            md_reg[k]    <= '0;
            sd_reg[k]    <= '0;
         end
         count_reg <= '0;
      end else if (flush_i) begin
         // Any beat offered this cycle is dropped; a beat leaving on the
         // output this cycle has already been taken by the consumer.
         for (int k = 0; k < STAGES; k++) begin
            state_reg[k] <= EMPTY;
            md_reg[k]    <= '0;
            sd_reg[k]    <= '0;
         end
         count_reg <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            state_reg[k] <= state_next[k];
            md_reg[k]    <= md_next[k];
            sd_reg[k]    <= sd_next[k];
         end
         count_reg <= count_next;
      end
   end

   // Gating with rst_i keeps in_ready_o low for the whole reset window.
   assign in_ready_o  = rst_i & ~state_reg[0][0];
   assign out_valid_o = state_reg[STAGES-1][1];
   assign out_data_o  = md_reg[STAGES-1];
   assign count_o     = count_reg;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_elastic
//
// Two instances: index 0 has STAGES=2, index 1 has STAGES=1. Only one of them
// carries traffic at a time, so a single scoreboard queue serves both.
// Inputs change 1 time unit after the rising edge; the monitor samples on the
// falling edge and predicts the transfers of the coming rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_reg_elastic;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush     [2];
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [31:0] in_data   [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [31:0] out_data  [2];
   logic [3:0]  count     [2];

   int          n_cmp = 0;
   int          n_err = 0;
   logic        toggle_en = 1'b0;
   logic [31:0] sb_q [$];
   logic        prev_pend [2];
   logic [31:0] prev_data [2];
   logic [31:0] exp_d;
   logic [3:0]  lim;

   always #5 clk = ~clk;

   pipe_reg_elastic #(.DATA_W(32), .STAGES(2), .CNT_W(4)) u_dut2 (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush[0]),
      .in_valid_i (in_valid[0]),
      .in_ready_o (in_ready[0]),
      .in_data_i  (in_data[0]),
      .out_valid_o(out_valid[0]),
      .out_ready_i(out_ready[0]),
      .out_data_o (out_data[0]),
      .count_o    (count[0])
   );

   pipe_reg_elastic #(.DATA_W(32), .STAGES(1), .CNT_W(4)) u_dut1 (
      .clk_i      (clk),
      .rst_i      (rst),
      .flush_i    (flush[1]),
      .in_valid_i (in_valid[1]),
      .in_ready_o (in_ready[1]),
      .in_data_i  (in_data[1]),
      .out_valid_o(out_valid[1]),
      .out_ready_i(out_ready[1]),
      .out_data_o (out_data[1]),
      .count_o    (count[1])
   );

   // Scoreboard monitor: pop/compare on output transfers, then flush or push.
   always @(negedge clk) begin
      if (!rst) begin
         sb_q.delete();
         prev_pend[0] = 1'b0;
         prev_pend[1] = 1'b0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (out_valid[k] && out_ready[k]) begin
               n_cmp++;
               assert (sb_q.size() > 0) else begin
                  n_err++;
                  $error("FAIL unexpected_out dut%0d observed %h expected no beat", k, out_data[k]);
               end
               if (sb_q.size() > 0) begin
                  exp_d = sb_q.pop_front();
                  $display("dut%0d out %h expected %h", k, out_data[k], exp_d);
                  n_cmp++;
                  assert (out_data[k] === exp_d) else begin
                     n_err++;
                     $error("FAIL out_order dut%0d observed %h expected %h", k, out_data[k], exp_d);
                  end
               end
            end
            if (flush[k]) sb_q.delete();
            else if (in_valid[k] && in_ready[k]) sb_q.push_back(in_data[k]);

            lim = (k == 0) ? 4'd4 : 4'd2;
            n_cmp++;
            assert (count[k] <= lim) else begin
               n_err++;
               $error("FAIL count_bound dut%0d observed %0d expected <= %0d", k, count[k], lim);
            end

            // Upstream protocol: a stalled beat must stay put until accepted.
            if (prev_pend[k]) begin
               n_cmp++;
               assert (in_valid[k] === 1'b1 && in_data[k] === prev_data[k]) else begin
                  n_err++;
                  $error("FAIL hold_stable dut%0d observed %b/%h expected 1/%h", k, in_valid[k], in_data[k], prev_data[k]);
               end
            end
            prev_pend[k] = in_valid[k] & ~in_ready[k] & ~flush[k];
            prev_data[k] = in_data[k];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Offer one beat and hold it until accepted; returns 1 unit after the
   // accepting edge. Optionally toggles out_ready every cycle.
   task automatic push_beat(input int k, input logic [31:0] d);
      logic rdy;
      logic got;
      got = 1'b0;
      in_valid[k] = 1'b1;
      in_data[k]  = d;
      for (int c = 0; c < 64 && !got; c++) begin
         @(negedge clk);
         rdy = in_ready[k];
         @(posedge clk);
         #1;
         if (toggle_en) out_ready[k] = ~out_ready[k];
         if (rdy) got = 1'b1;
      end
      n_cmp++;
      assert (got === 1'b1) else begin
         n_err++;
         $error("FAIL push_timeout dut%0d observed ready=0 expected ready=1", k);
      end
   endtask

   task automatic drain(input int k);
      logic done;
      done = 1'b0;
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      for (int c = 0; c < 64 && !done; c++) begin
         @(posedge clk);
         #1;
         if (count[k] == 4'd0 && !out_valid[k]) done = 1'b1;
      end
      n_cmp++;
      assert (done === 1'b1) else begin
         n_err++;
         $error("FAIL drain_timeout dut%0d observed count %0d expected 0", k, count[k]);
      end
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         flush[k]     = 1'b0;
         in_valid[k]  = 1'b0;
         in_data[k]   = '0;
         out_ready[k] = 1'b0;
         prev_pend[k] = 1'b0;
         prev_data[k] = '0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
      chk("rst_count", 32'(count[0]), 32'd0);
      rst = 1'b1;
      #1;
      chk("rel_in_ready2", 32'(in_ready[0]), 32'd1);
      chk("rel_in_ready1", 32'(in_ready[1]), 32'd1);
      @(posedge clk);
      #1;

      // Stream 0x1..0x8 through STAGES=2
      out_ready[0] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         push_beat(0, 32'(i));
         if (i == 1) begin
            chk("lat_not_yet", 32'(out_valid[0]), 32'd0);
            chk("stream_count1", 32'(count[0]), 32'd1);
         end else begin
            chk("stream_valid", 32'(out_valid[0]), 32'd1);
            chk("stream_data", out_data[0], 32'(i - 1));
            chk("stream_count", 32'(count[0]), 32'd2);
         end
      end
      in_valid[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("tail_data", out_data[0], 32'h8);
      chk("tail_count", 32'(count[0]), 32'd1);
      @(posedge clk);
      #1;
      chk("idle_valid", 32'(out_valid[0]), 32'd0);
      chk("idle_count", 32'(count[0]), 32'd0);

      // Backpressure fill
      out_ready[0] = 1'b0;
      for (int i = 0; i < 4; i++) push_beat(0, 32'hA0 + 32'(i));
      in_data[0] = 32'hA4;
      repeat (2) @(posedge clk);
      #1;
      chk("full_in_ready", 32'(in_ready[0]), 32'd0);
      chk("full_count", 32'(count[0]), 32'd4);
      chk("full_head", out_data[0], 32'hA0);
      chk("held_input", in_data[0], 32'hA4);
      out_ready[0] = 1'b1;
      #1;
      chk("no_comb_ready", 32'(in_ready[0]), 32'd0);
      @(posedge clk);
      #1;
      out_ready[0] = 1'b0;
      chk("one_freed", 32'(count[0]), 32'd3);
      chk("still_blocked", 32'(in_ready[0]), 32'd0);
      out_ready[0] = 1'b1;
      push_beat(0, 32'hA4);
      push_beat(0, 32'hA5);
      drain(0);

      // Ready toggling with 100 random beats
      toggle_en = 1'b1;
      for (int i = 0; i < 100; i++) push_beat(0, $urandom);
      toggle_en = 1'b0;
      drain(0);

      // Flush mid-stream with a beat offered
      out_ready[0] = 1'b0;
      for (int i = 0; i < 3; i++) push_beat(0, 32'hB0 + 32'(i));
      chk("pre_flush_count", 32'(count[0]), 32'd3);
      in_data[0]   = 32'hFF;
      flush[0]     = 1'b1;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      flush[0]    = 1'b0;
      in_valid[0] = 1'b0;
      chk("flush_count", 32'(count[0]), 32'd0);
      chk("flush_valid", 32'(out_valid[0]), 32'd0);
      chk("flush_data", out_data[0], 32'd0);
      chk("flush_ready", 32'(in_ready[0]), 32'd1);
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("flush_no_ff", 32'(out_valid[0]), 32'd0);
      end

      // Async reset while full
      out_ready[0] = 1'b0;
      for (int i = 0; i < 4; i++) push_beat(0, 32'hC0 + 32'(i));
      in_valid[0] = 1'b0;
      chk("pre_rst_count", 32'(count[0]), 32'd4);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid[0]), 32'd0);
      chk("arst_ready", 32'(in_ready[0]), 32'd0);
      chk("arst_data", out_data[0], 32'd0);
      chk("arst_count", 32'(count[0]), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_rel_ready", 32'(in_ready[0]), 32'd1);
      @(posedge clk);
      #1;

      // STAGES=1: accept and drain in the same cycle
      out_ready[1] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push_beat(1, 32'h10 + 32'(i));
         chk("s1_valid", 32'(out_valid[1]), 32'd1);
         chk("s1_data", out_data[1], 32'h10 + 32'(i));
         chk("s1_count", 32'(count[1]), 32'd1);
      end
      in_valid[1] = 1'b0;
      @(posedge clk);
      #1;
      chk("s1_idle_valid", 32'(out_valid[1]), 32'd0);
      chk("s1_idle_count", 32'(count[1]), 32'd0);
      chk("s1_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
